// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main controller: ALU operation codes,
// opcode/funct constants and the controller state encoding.
package mc_control_fsm_pkg;

    localparam int STATE_W = 4;
    localparam int ALUOP_W = 6;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP  = 6'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 6'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU = 6'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 6'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU = 6'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 6'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 6'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 6'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR  = 6'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 6'd9;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 6'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 6'd11;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 6'd12;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 6'd13;
    localparam logic [ALUOP_W-1:0] ALUOP_SLLV = 6'd14;
    localparam logic [ALUOP_W-1:0] ALUOP_SRLV = 6'd15;
    localparam logic [ALUOP_W-1:0] ALUOP_SRAV = 6'd16;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JAL      = 4'd11,
        S_JR       = 4'd12
    } state_t;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational opcode/funct decode for the execute states: ALU operation, immediate
// extension mode, shift-by-shamt detection and recognition of supported encodings.
module mc_alu_decoder
    import mc_control_fsm_pkg::*;
#(
    parameter int ALUOP_W = mc_control_fsm_pkg::ALUOP_W
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               ext_op,
    output logic               shift_imm,
    output logic               alu_imm,
    output logic               illegal_funct
);

    always_comb begin
        alu_op        = ALUOP_ADD;
        ext_op        = 1'b1;
        shift_imm     = 1'b0;
        alu_imm       = 1'b1;
        illegal_funct = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_imm = 1'b0;
                ext_op  = 1'b0;
                case (funct)
                    FUNCT_ADD:  alu_op = ALUOP_ADD;
                    FUNCT_ADDU: alu_op = ALUOP_ADDU;
                    FUNCT_SUB:  alu_op = ALUOP_SUB;
                    FUNCT_SUBU: alu_op = ALUOP_SUBU;
                    FUNCT_AND:  alu_op = ALUOP_AND;
                    FUNCT_OR:   alu_op = ALUOP_OR;
                    FUNCT_XOR:  alu_op = ALUOP_XOR;
                    FUNCT_NOR:  alu_op = ALUOP_NOR;
                    FUNCT_SLT:  alu_op = ALUOP_SLT;
                    FUNCT_SLTU: alu_op = ALUOP_SLTU;
                    FUNCT_SLLV: alu_op = ALUOP_SLLV;
                    FUNCT_SRLV: alu_op = ALUOP_SRLV;
                    FUNCT_SRAV: alu_op = ALUOP_SRAV;
                    FUNCT_SLL:  begin alu_op = ALUOP_SLL; shift_imm = 1'b1; end
                    FUNCT_SRL:  begin alu_op = ALUOP_SRL; shift_imm = 1'b1; end
                    FUNCT_SRA:  begin alu_op = ALUOP_SRA; shift_imm = 1'b1; end
                    FUNCT_JR:   alu_op = ALUOP_NOP;
                    default:    illegal_funct = 1'b1;
                endcase
            end
            OP_ADDI:  alu_op = ALUOP_ADD;
            OP_ADDIU: alu_op = ALUOP_ADDU;
            OP_SLTI:  alu_op = ALUOP_SLT;
            OP_SLTIU: alu_op = ALUOP_SLTU;
            OP_ANDI:  begin alu_op = ALUOP_AND; ext_op = 1'b0; end
            OP_ORI:   begin alu_op = ALUOP_OR;  ext_op = 1'b0; end
            OP_XORI:  begin alu_op = ALUOP_XOR; ext_op = 1'b0; end
            // The datapath applies the fixed 16-bit shift that turns SLL into lui.
            OP_LUI:   alu_op = ALUOP_SLL;
            default:  alu_imm = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB and decodes all
// datapath selects and write enables from the current state.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int ALUOP_W = mc_control_fsm_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_op,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal
);

    state_t state_q, state_d;
    // Low from reset until the first edge after release, so nothing is requested while in reset.
    logic   active_q;

    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_ext_op;
    logic               dec_shift_imm;
    logic               dec_alu_imm;
    logic               dec_illegal_funct;

    mc_alu_decoder #(.ALUOP_W(ALUOP_W)) u_alu_decoder (
        .opcode        (opcode),
        .funct         (funct),
        .alu_op        (dec_alu_op),
        .ext_op        (dec_ext_op),
        .shift_imm     (dec_shift_imm),
        .alu_imm       (dec_alu_imm),
        .illegal_funct (dec_illegal_funct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        ext_op     = 1'b0;
        pc_source  = 2'd0;
        alu_op     = '0;
        illegal    = 1'b0;
        if (!active_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    alu_op    = ALUOP_ADD;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_en    = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                    ext_op    = 1'b1;
                    alu_op    = ALUOP_ADD;
                    case (opcode)
                        OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                        OP_J:            state_d = S_JUMP;
                        OP_JAL:          state_d = S_JAL;
                        OP_RTYPE: begin
                            if (funct == FUNCT_JR) begin
                                state_d = S_JR;
                            end else if (dec_illegal_funct) begin
                                illegal = 1'b1;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_EXEC_R;
                            end
                        end
                        default: begin
                            if (dec_alu_imm) begin
                                state_d = S_EXEC_I;
                            end else begin
                                illegal = 1'b1;
                                state_d = S_FETCH;
                            end
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    ext_op    = 1'b1;
                    alu_op    = ALUOP_ADD;
                    state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = dec_shift_imm ? 2'd2 : 2'd1;
                    alu_op    = dec_alu_op;
                    state_d   = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    ext_op    = dec_ext_op;
                    alu_op    = dec_alu_op;
                    state_d   = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'd1;
                    alu_op    = ALUOP_SUB;
                    pc_source = 2'd1;
                    pc_en     = zero ^ (opcode == OP_BNE);
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_source = 2'd2;
                    pc_en     = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JAL: begin
                    pc_source  = 2'd2;
                    pc_en      = 1'b1;
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    state_d    = S_FETCH;
                end
                S_JR: begin
                    pc_source = 2'd3;
                    pc_en     = 1'b1;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, hand-written wait/reset sequences and a
// random instruction stream checked against an instruction-level reference model.
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, ext_op, illegal;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic [5:0] alu_op;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .pc_source(pc_source),
        .alu_op(alu_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b;
        logic       ext_op;
        logic [1:0] pc_source;
        logic [5:0] alu_op;
        logic       illegal;
    } ctl_t;

    ctl_t act;
    assign act = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, ext_op, pc_source, alu_op, illegal};

    int checks = 0;
    int failures = 0;

    function automatic ctl_t mk(bit pe, bit io, bit mr, bit mw, bit irw, bit rw, int rd, int m2r,
                                int sa, int sb, bit ex, int ps, logic [5:0] aop, bit ill);
        ctl_t c;
        c.pc_en = pe; c.iord = io; c.mem_read = mr; c.mem_write = mw;
        c.ir_write = irw; c.reg_write = rw; c.reg_dst = 2'(rd); c.mem_to_reg = 2'(m2r);
        c.alu_src_a = 2'(sa); c.alu_src_b = 2'(sb); c.ext_op = ex; c.pc_source = 2'(ps);
        c.alu_op = aop; c.illegal = ill;
        return c;
    endfunction

    task automatic chk(input string name, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic mr, input logic z);
        @(negedge clk);
        opcode = op; funct = fn; mem_ready = mr; zero = z;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      name;
        logic [5:0] op, fn;
        logic       mr, z;
        ctl_t       exp;
    } vec_t;
    vec_t vecs[$];

    // ---------------- instruction-level reference model ----------------
    typedef enum {K_LW, K_SW, K_R, K_JR, K_I, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;
    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_XR, P_XI, P_WB, P_BR, P_J, P_JAL, P_JR} ph_t;
    typedef struct {
        logic [5:0] op, fn;
        kind_t      kind;
        logic [5:0] aop;
        logic       ext, sh;
    } ins_t;
    ins_t ilist[$];

    function automatic ctl_t expect_ctl(ph_t ph, ins_t ins, logic mr, logic z);
        ctl_t e = '0;
        case (ph)
            P_F:   begin e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_op = ALUOP_ADD;
                         e.ir_write = mr; e.pc_en = mr; end
            P_D:   begin e.alu_src_b = 2'd3; e.ext_op = 1; e.alu_op = ALUOP_ADD;
                         e.illegal = (ins.kind == K_ILL); end
            P_MA:  begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.ext_op = 1; e.alu_op = ALUOP_ADD; end
            P_MR:  begin e.mem_read = 1; e.iord = 1; end
            P_MW:  begin e.mem_write = 1; e.iord = 1; end
            P_MWB: begin e.reg_write = 1; e.mem_to_reg = 2'd1; end
            P_XR:  begin e.alu_src_a = ins.sh ? 2'd2 : 2'd1; e.alu_op = ins.aop; end
            P_XI:  begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.ext_op = ins.ext; e.alu_op = ins.aop; end
            P_WB:  begin e.reg_write = 1; e.reg_dst = (ins.kind == K_R) ? 2'd1 : 2'd0; end
            P_BR:  begin e.alu_src_a = 2'd1; e.alu_op = ALUOP_SUB; e.pc_source = 2'd1;
                         e.pc_en = (ins.kind == K_BNE) ? !z : z; end
            P_J:   begin e.pc_source = 2'd2; e.pc_en = 1; end
            P_JAL: begin e.pc_source = 2'd2; e.pc_en = 1; e.reg_write = 1; e.reg_dst = 2'd2;
                         e.mem_to_reg = 2'd2; end
            P_JR:  begin e.pc_source = 2'd3; e.pc_en = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    initial begin
        ctl_t F1, F0, DEC, MA, RWB;
        ph_t  q[$];
        ins_t cur;
        int   mw_cnt, rw_cnt;
        logic mr_r, z_r;
        logic [5:0] fn_r;

        F1  = mk(1,0,1,0,1,0,0,0,0,1,0,0,ALUOP_ADD,0);
        F0  = mk(0,0,1,0,0,0,0,0,0,1,0,0,ALUOP_ADD,0);
        DEC = mk(0,0,0,0,0,0,0,0,0,3,1,0,ALUOP_ADD,0);
        MA  = mk(0,0,0,0,0,0,0,0,1,2,1,0,ALUOP_ADD,0);
        RWB = mk(0,0,0,0,0,1,1,0,0,0,0,0,6'd0,0);

        vecs.push_back('{"lw_fetch",   6'b100011, 6'd0, 1'b1, 1'b0, F1});
        vecs.push_back('{"lw_decode",  6'b100011, 6'd0, 1'b0, 1'b0, DEC});
        vecs.push_back('{"lw_addr",    6'b100011, 6'd0, 1'b0, 1'b1, MA});
        vecs.push_back('{"lw_memrd",   6'b100011, 6'd0, 1'b1, 1'b0, mk(0,1,1,0,0,0,0,0,0,0,0,0,6'd0,0)});
        vecs.push_back('{"lw_memwb",   6'b100011, 6'd0, 1'b0, 1'b0, mk(0,0,0,0,0,1,0,1,0,0,0,0,6'd0,0)});
        vecs.push_back('{"add_fwait",  6'b000000, 6'b100000, 1'b0, 1'b0, F0});
        vecs.push_back('{"add_fetch",  6'b000000, 6'b100000, 1'b1, 1'b0, F1});
        vecs.push_back('{"add_decode", 6'b000000, 6'b100000, 1'b1, 1'b0, DEC});
        vecs.push_back('{"add_exec",   6'b000000, 6'b100000, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1,0,0,0,ALUOP_ADD,0)});
        vecs.push_back('{"add_wb",     6'b000000, 6'b100000, 1'b1, 1'b0, RWB});
        vecs.push_back('{"sll_fetch",  6'b000000, 6'b000000, 1'b1, 1'b0, F1});
        vecs.push_back('{"sll_decode", 6'b000000, 6'b000000, 1'b0, 1'b0, DEC});
        vecs.push_back('{"sll_exec",   6'b000000, 6'b000000, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,2,0,0,0,ALUOP_SLL,0)});
        vecs.push_back('{"sll_wb",     6'b000000, 6'b000000, 1'b0, 1'b0, RWB});
        vecs.push_back('{"ori_fetch",  6'b001101, 6'b101010, 1'b1, 1'b0, F1});
        vecs.push_back('{"ori_decode", 6'b001101, 6'b101010, 1'b0, 1'b0, DEC});
        vecs.push_back('{"ori_exec",   6'b001101, 6'b101010, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1,2,0,0,ALUOP_OR,0)});
        vecs.push_back('{"ori_wb",     6'b001101, 6'b101010, 1'b0, 1'b0, mk(0,0,0,0,0,1,0,0,0,0,0,0,6'd0,0)});
        vecs.push_back('{"beq1_fetch", 6'b000100, 6'd0, 1'b1, 1'b0, F1});
        vecs.push_back('{"beq1_dec",   6'b000100, 6'd0, 1'b0, 1'b0, DEC});
        vecs.push_back('{"beq_taken",  6'b000100, 6'd0, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,0,1,0,0,1,ALUOP_SUB,0)});
        vecs.push_back('{"beq0_fetch", 6'b000100, 6'd0, 1'b1, 1'b0, F1});
        vecs.push_back('{"beq0_dec",   6'b000100, 6'd0, 1'b0, 1'b0, DEC});
        vecs.push_back('{"beq_not",    6'b000100, 6'd0, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,1,0,0,1,ALUOP_SUB,0)});
        vecs.push_back('{"bne0_fetch", 6'b000101, 6'd0, 1'b1, 1'b0, F1});
        vecs.push_back('{"bne0_dec",   6'b000101, 6'd0, 1'b0, 1'b0, DEC});
        vecs.push_back('{"bne_taken",  6'b000101, 6'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,1,0,0,1,ALUOP_SUB,0)});
        vecs.push_back('{"bne1_fetch", 6'b000101, 6'd0, 1'b1, 1'b0, F1});
        vecs.push_back('{"bne1_dec",   6'b000101, 6'd0, 1'b0, 1'b0, DEC});
        vecs.push_back('{"bne_not",    6'b000101, 6'd0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,1,0,0,1,ALUOP_SUB,0)});
        vecs.push_back('{"jal_fetch",  6'b000011, 6'd0, 1'b1, 1'b0, F1});
        vecs.push_back('{"jal_dec",    6'b000011, 6'd0, 1'b0, 1'b0, DEC});
        vecs.push_back('{"jal_exec",   6'b000011, 6'd0, 1'b0, 1'b0, mk(1,0,0,0,0,1,2,2,0,0,0,2,6'd0,0)});
        vecs.push_back('{"ill_fetch",  6'b111111, 6'd0, 1'b1, 1'b0, F1});
        vecs.push_back('{"ill_dec",    6'b111111, 6'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,3,1,0,ALUOP_ADD,1)});
        vecs.push_back('{"ill_refetch",6'b000000, 6'b001000, 1'b1, 1'b0, F1});
        vecs.push_back('{"jr_dec",     6'b000000, 6'b001000, 1'b0, 1'b0, DEC});
        vecs.push_back('{"jr_exec",    6'b000000, 6'b001000, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,3,6'd0,0)});

        ilist.push_back('{6'b100011, 6'd0, K_LW, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b101011, 6'd0, K_SW, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100000, K_R, ALUOP_ADD,  1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100001, K_R, ALUOP_ADDU, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100010, K_R, ALUOP_SUB,  1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100011, K_R, ALUOP_SUBU, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100100, K_R, ALUOP_AND,  1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100101, K_R, ALUOP_OR,   1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100110, K_R, ALUOP_XOR,  1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b100111, K_R, ALUOP_NOR,  1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b101010, K_R, ALUOP_SLT,  1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b101011, K_R, ALUOP_SLTU, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b000000, K_R, ALUOP_SLL,  1'b0, 1'b1});
        ilist.push_back('{6'b000000, 6'b000010, K_R, ALUOP_SRL,  1'b0, 1'b1});
        ilist.push_back('{6'b000000, 6'b000011, K_R, ALUOP_SRA,  1'b0, 1'b1});
        ilist.push_back('{6'b000000, 6'b000100, K_R, ALUOP_SLLV, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b000110, K_R, ALUOP_SRLV, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b000111, K_R, ALUOP_SRAV, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b001000, K_JR, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b000000, 6'b001001, K_ILL, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b001000, 6'd0, K_I, ALUOP_ADD,  1'b1, 1'b0});
        ilist.push_back('{6'b001001, 6'd0, K_I, ALUOP_ADDU, 1'b1, 1'b0});
        ilist.push_back('{6'b001010, 6'd0, K_I, ALUOP_SLT,  1'b1, 1'b0});
        ilist.push_back('{6'b001011, 6'd0, K_I, ALUOP_SLTU, 1'b1, 1'b0});
        ilist.push_back('{6'b001100, 6'd0, K_I, ALUOP_AND,  1'b0, 1'b0});
        ilist.push_back('{6'b001101, 6'd0, K_I, ALUOP_OR,   1'b0, 1'b0});
        ilist.push_back('{6'b001110, 6'd0, K_I, ALUOP_XOR,  1'b0, 1'b0});
        ilist.push_back('{6'b001111, 6'd0, K_I, ALUOP_SLL,  1'b1, 1'b0});
        ilist.push_back('{6'b000100, 6'd0, K_BEQ, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b000101, 6'd0, K_BNE, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b000010, 6'd0, K_J,   6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b000011, 6'd0, K_JAL, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b111111, 6'd0, K_ILL, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b100000, 6'd0, K_ILL, 6'd0, 1'b0, 1'b0});
        ilist.push_back('{6'b010000, 6'd0, K_ILL, 6'd0, 1'b0, 1'b0});

        // reset: held low three cycles with mem_ready high, nothing may be requested
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("reset_idle", '0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].fn, vecs[i].mr, vecs[i].z);
            chk(vecs[i].name, vecs[i].exp);
        end

        // sw with memory stalling three cycles in MEM_WR
        mw_cnt = 0; rw_cnt = 0;
        step(6'b101011, 6'd0, 1'b1, 1'b0); chk("sw_fetch", F1);
        step(6'b101011, 6'd0, 1'b0, 1'b0); chk("sw_decode", DEC);
        step(6'b101011, 6'd0, 1'b0, 1'b0); chk("sw_addr", MA);
        for (int i = 0; i < 4; i++) begin
            step(6'b101011, 6'd0, (i == 3), 1'b0);
            chk("sw_memwr", mk(0,1,0,1,0,0,0,0,0,0,0,0,6'd0,0));
            mw_cnt += int'(mem_write);
            rw_cnt += int'(reg_write);
        end
        step(6'b000010, 6'd0, 1'b0, 1'b0); chk("sw_back_fetch", F0);
        chk_int("sw_mem_write_cycles", mw_cnt, 4);
        chk_int("sw_reg_write_cycles", rw_cnt, 0);
        step(6'b000010, 6'd0, 1'b1, 1'b0); chk("j_fetch", F1);
        step(6'b000010, 6'd0, 1'b0, 1'b0); chk("j_decode", DEC);
        step(6'b000010, 6'd0, 1'b0, 1'b0); chk("j_exec", mk(1,0,0,0,0,0,0,0,0,0,0,2,6'd0,0));

        // asynchronous reset in the middle of a stalled store
        step(6'b101011, 6'd0, 1'b1, 1'b0); chk("rst_sw_fetch", F1);
        step(6'b101011, 6'd0, 1'b0, 1'b0); chk("rst_sw_decode", DEC);
        step(6'b101011, 6'd0, 1'b0, 1'b0); chk("rst_sw_addr", MA);
        step(6'b101011, 6'd0, 1'b0, 1'b0); chk("rst_sw_memwr", mk(0,1,0,1,0,0,0,0,0,0,0,0,6'd0,0));
        #1 rst_n = 1'b0;
        #1 chk("async_reset_mid", '0);
        @(negedge clk);
        #1 chk("async_reset_hold", '0);
        rst_n = 1'b1;

        // random instruction stream against the reference model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (q.size() == 0) begin
                cur = ilist[$urandom_range(0, ilist.size() - 1)];
                case (cur.kind)
                    K_LW:          q = '{P_F, P_D, P_MA, P_MR, P_MWB};
                    K_SW:          q = '{P_F, P_D, P_MA, P_MW};
                    K_R:           q = '{P_F, P_D, P_XR, P_WB};
                    K_I:           q = '{P_F, P_D, P_XI, P_WB};
                    K_JR:          q = '{P_F, P_D, P_JR};
                    K_BEQ, K_BNE:  q = '{P_F, P_D, P_BR};
                    K_J:           q = '{P_F, P_D, P_J};
                    K_JAL:         q = '{P_F, P_D, P_JAL};
                    default:       q = '{P_F, P_D};
                endcase
            end
            mr_r = ($urandom_range(0, 9) < 6);
            z_r  = 1'($urandom_range(0, 1));
            fn_r = (cur.op == 6'd0) ? cur.fn : 6'($urandom);
            step(cur.op, fn_r, mr_r, z_r);
            chk("random", expect_ctl(q[0], cur, mr_r, z_r));
            if (!((q[0] == P_F || q[0] == P_MR || q[0] == P_MW) && !mr_r))
                void'(q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
